// File: rtl/util_sync_send_pkg.sv
// Shared definitions for the two-phase request/acknowledge sender:
// FSM encodings, the completed-transfer counter width and watchdog sizing.
package util_sync_send_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } send_state_e;

  localparam int unsigned XFER_CNT_W = 16;

  // Watchdog counter width: it only ever needs to reach limit-1.
  function automatic int unsigned wd_width(input int unsigned limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/util_sync_flops.sv
// Multi-stage flop synchronizer for bringing asynchronous levels into clk.
// Every stage resets to SYNC_RESET_VALUE so the output is known during reset.
module util_sync_flops #(
  parameter int unsigned WIDTH            = 1,
  parameter int unsigned STAGES           = 2,
  parameter logic        SYNC_RESET_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= {WIDTH{SYNC_RESET_VALUE}};
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/util_sync_send.sv
// Sender side of a two-phase toggle handshake: captures a word, flips xfer_req,
// and waits for the synchronized acknowledge toggle before accepting the next.
module util_sync_send
  import util_sync_send_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  xfer_req,
  output logic [WIDTH-1:0]      xfer_data,
  input  logic                  xfer_ack,
  output logic                  done,
  output logic [XFER_CNT_W-1:0] xfer_count,
  output logic                  timeout_err,
  output logic                  proto_err,
  input  logic                  err_clr
);

  localparam int unsigned     WD_W   = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic            WD_EN  = (TIMEOUT_CYCLES != 0);

  logic                  ack_s;

  send_state_e           state_q, state_d;
  logic                  req_q, req_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  done_q, done_d;
  logic [XFER_CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  terr_q, terr_d;
  logic                  perr_q, perr_d;
  logic                  terr_set, perr_set;

  // The raw acknowledge is asynchronous; only ack_s is used below.
  util_sync_flops #(
    .WIDTH            (1),
    .STAGES           (2),
    .SYNC_RESET_VALUE (1'b0)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (xfer_ack),
    .q_o   (ack_s)
  );

  assign in_ready = (state_q == ST_IDLE) && (ack_s == req_q);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    terr_set = 1'b0;
    perr_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ack_s != req_q) begin
          perr_set = 1'b1;
        end else if (in_valid) begin
          data_d  = in_data;
          req_d   = ~req_q;
          wd_d    = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          // No abort on timeout: the transfer may still complete late.
          if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
          end
          if (WD_EN && (wd_q == WD_MAX)) begin
            terr_set = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A set in the same cycle beats a clear.
    terr_d = terr_set | (terr_q & ~err_clr);
    perr_d = perr_set | (perr_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
    end
  end

  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign done        = done_q;
  assign xfer_count  = cnt_q;
  assign timeout_err = terr_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_util_sync_send.sv
// Directed bench for util_sync_send: handshake latency, back-to-back loopback,
// watchdog, spurious acknowledge, asynchronous reset and counter wrap.
module tb_util_sync_send;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        xfer_req;
  logic [31:0] xfer_data;
  logic        xfer_ack;
  logic        done;
  logic [15:0] xfer_count;
  logic        timeout_err;
  logic        proto_err;
  logic        err_clr;

  logic        ack_man;
  logic        loop_en;
  logic        ld1, ld2;

  int vectors;
  int miscompares;

  util_sync_send #(
    .WIDTH          (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .xfer_req    (xfer_req),
    .xfer_data   (xfer_data),
    .xfer_ack    (xfer_ack),
    .done        (done),
    .xfer_count  (xfer_count),
    .timeout_err (timeout_err),
    .proto_err   (proto_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remote loopback model: echoes xfer_req back two cycles later.
  always @(posedge clk) begin
    ld1 <= xfer_req;
    ld2 <= ld1;
  end
  assign xfer_ack = loop_en ? ld2 : ack_man;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int dones;
    logic acc;

    vectors = 0; miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
    ack_man = 1'b0; loop_en = 1'b0;

    // Reset state
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_done", done, 0);
    chk("rst_count", xfer_count, 0);
    chk("rst_errs", {timeout_err, proto_err}, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", in_ready, 1);

    // Single transfer
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0; in_data = 32'h0;
    chk("t1_req", xfer_req, 1);
    chk("t1_data", xfer_data, 32'hDEADBEEF);
    chk("t1_busy", in_ready, 0);
    for (int i = 0; i < 5; i++) step();
    chk("t1_no_done", done, 0);
    ack_man = 1'b1;
    step();
    chk("t1_lat1", done, 0);
    step();
    chk("t1_lat2", done, 0);
    chk("t1_hold", xfer_data, 32'hDEADBEEF);
    step();
    chk("t1_done", done, 1);
    chk("t1_count", xfer_count, 1);
    chk("t1_ready", in_ready, 1);
    step();
    chk("t1_pulse_end", done, 0);

    // Back-to-back with loopback ack
    loop_en = 1'b1;
    idx = 0; dones = 0;
    in_valid = 1'b1; in_data = 32'h1;
    for (int c = 0; c < 200 && dones < 4; c++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        chk("b2b_cap", xfer_data, idx + 1);
        idx++;
        if (idx < 4) in_data = idx + 1;
        else begin in_valid = 1'b0; in_data = '0; end
      end else if (idx > 0) begin
        chk("b2b_stable", xfer_data, idx);
      end
      if (done) dones++;
    end
    chk("b2b_dones", dones, 4);
    chk("b2b_count", xfer_count, 5);
    chk("b2b_errs", {timeout_err, proto_err}, 0);
    ack_man = 1'b1;
    loop_en = 1'b0;
    step(); step(); step();

    // Watchdog
    in_valid = 1'b1; in_data = 32'hA5;
    step();
    in_valid = 1'b0;
    chk("wd_req", xfer_req, 0);
    for (int i = 0; i < 15; i++) step();
    chk("wd_before", timeout_err, 0);
    step();
    chk("wd_set", timeout_err, 1);
    chk("wd_stay", in_ready, 0);
    for (int i = 0; i < 5; i++) step();
    chk("wd_no_done", done, 0);
    chk("wd_sticky", timeout_err, 1);
    ack_man = 1'b0;
    step(); step();
    chk("wd_late_lat", done, 0);
    step();
    chk("wd_late_done", done, 1);
    chk("wd_count", xfer_count, 6);
    chk("wd_err_kept", timeout_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wd_clr", timeout_err, 0);

    // Spurious acknowledge in IDLE
    ack_man = 1'b1;
    step(); step();
    chk("sp_ready_drop", in_ready, 0);
    chk("sp_not_yet", proto_err, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("sp_set_wins", proto_err, 1);
    step();
    chk("sp_ready_low", in_ready, 0);
    ack_man = 1'b0;
    step();
    chk("sp_ready_still_low", in_ready, 0);
    step();
    chk("sp_ready_back", in_ready, 1);
    chk("sp_sticky", proto_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("sp_clr", proto_err, 0);

    // Reset mid-transfer
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    chk("mr_req", xfer_req, 1);
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_req0", xfer_req, 0);
    chk("mr_data0", xfer_data, 0);
    chk("mr_count0", xfer_count, 0);
    chk("mr_done0", done, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_errs", {timeout_err, proto_err}, 0);
    step();
    rst_n = 1'b1;
    step();

    // Counter wrap from a preloaded 0xFFFF
    dut.cnt_q = 16'hFFFF;
    step();
    chk("wr_preload", xfer_count, 16'hFFFF);
    in_valid = 1'b1; in_data = 32'h77;
    step();
    in_valid = 1'b0;
    chk("wr_req", xfer_req, 1);
    ack_man = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) dones++;
    end
    chk("wr_once", dones, 1);
    chk("wr_count", xfer_count, 16'h0000);
    chk("wr_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
